jtag_scan_sequencer: RTL and testbench
======================================

Name: jtag_scan_sequencer

Overview:
- Clk-domain JTAG master that drives the team's 1149.1 TAP (IR_WIDTH-bit IR, DR_WIDTH-bit DR) from a simple command/response interface.
- Generates TCK/TMS/TDI bit-sequences for TAP reset, IR scan, DR scan and idle clocking, and collects TDO into a response word.
- Sits between an on-chip test/debug host and the TAP.
- Also serves as the reference stimulus engine for TAP regressions.

Parameters:
- IR_WIDTH, 5, TAP instruction register length (≥2)
- DR_WIDTH, 32, TAP data register length and command/response word width (≥16)
- CLK_DIV, 4, clk cycles per TCK half-period (≥1)

Ports:
- clk  input  1  system clock
- trst_n  input  1  reset, asynchronous, active-low; also routed to the TAP trst_n
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accept; transfer when cmd_valid&cmd_ready
- cmd_type  input  2  00 TAP_RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE_CLK
- cmd_ir  input  IR_WIDTH  IR value to shift (IR_SCAN)
- cmd_dr  input  DR_WIDTH  DR value to shift (DR_SCAN); cmd_dr[15:0] = TCK count (IDLE_CLK)
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when rsp_valid&rsp_ready
- rsp_data  output  DR_WIDTH  captured TDO bits, LSB = first bit out
- busy  output  1  high from command accept until response handshake
- tap_synced  output  1  sequencer knows the TAP is in Run-Test/Idle
- tck  output  1  test clock
- tms  output  1  test mode select
- tdi  output  1  test data in
- tdo  input  1  test data out from TAP

Behaviour:
- Reset (async): tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, tap_synced=0; all counters cleared.
- Reset mid-operation aborts immediately. No response is generated for the aborted command.
- FSM states: IDLE → LOAD → TCK_LO ⇄ TCK_HI → RSP → IDLE.
- IDLE: cmd_ready=1. On accept, latch all command fields, go to LOAD.
- LOAD: build TMS/TDI bit plan and total TCK count; clear rsp shift register.
- TCK_LO: tck=0 for CLK_DIV clk.
  - tms/tdi change only on entry to TCK_LO (TCK falling edge).
- TCK_HI: tck=1 for CLK_DIV clk.
  - tdo sampled on entry to TCK_HI (TCK rising edge), only for shift bits.
- TCK period = 2*CLK_DIV clk, 50% duty.
- TMS plans, starting from Run-Test/Idle:
  - TAP_RESET: 1,1,1,1,1,0 (6 TCK). Sets tap_synced=1 on completion.
  - IR_SCAN: 1,1,0,0, then IR_WIDTH shift bits (TMS=0, last TMS=1), then 1,0. Total IR_WIDTH+6 TCK.
  - DR_SCAN: 1,0,0, then DR_WIDTH shift bits (last TMS=1), then 1,0. Total DR_WIDTH+5 TCK.
  - IDLE_CLK: N TCK with tms=0, N=cmd_dr[15:0].
    - N=0: no TCK; LOAD goes straight to RSP.
    - Requires tap_synced; otherwise treated as TAP_RESET followed by N idle TCKs.
- Shift data: tdi = cmd_ir/cmd_dr bit i on shift bit i, LSB first. tdi=0 outside shift bits.
- Capture: TDO bit i is stored to rsp_data[i]. IR capture is zero-extended to DR_WIDTH. rsp_data=0 for TAP_RESET/IDLE_CLK.
- Auto-sync: an IR_SCAN/DR_SCAN accepted while tap_synced=0 is prefixed by the 6-TCK TAP_RESET plan.
- Command end: after the final TCK_HI completes, tck returns low and tms holds 0.
- RSP: rsp_valid=1 one clk after the final TCK_HI ends; rsp_data held stable.
  - cmd_ready=0 and no TCK activity until the rsp handshake.
  - After the handshake, rsp_valid=0 and cmd_ready=1 in the next cycle.
- busy = (state != IDLE).
- cmd_ready=0 in every state except IDLE; commands presented while busy wait.
- Illegal cmd_type: none, since all 4 encodings are defined.

Test Plan:
- Reset, then DR_SCAN cmd_dr=0xA5A50F0F with TAP dr_in=0x12345678 -> 43 TCK (6 prefix + 37), rsp_data=0x12345678, TAP dr_out=0xA5A50F0F, tap_synced=1.
- IR_SCAN cmd_ir=5'b00011 when synced -> 11 TCK, TAP instruction=5'b00011, rsp_data=0x0000000F (captured 01111).
- CLK_DIV=4 -> every TCK high/low phase exactly 4 clk; tms/tdi transitions only coincide with tck falling; bench asserts tdi stable at every tck rise.
- IDLE_CLK N=0 -> rsp_valid within 2 clk of accept, zero TCK pulses; N=3 -> exactly 3 TCK pulses, tms=0, TAP remains Run-Test/Idle.
- rsp_ready held low 20 clk after a DR_SCAN -> rsp_valid=1, rsp_data constant, cmd_ready=0, tck=0 throughout; a new cmd_valid is not accepted until rsp_ready pulses.
- trst_n asserted after 10 DR shift bits -> same-cycle outputs tck=0, tms=1, busy=0, tap_synced=0, no response; next DR_SCAN includes the 6-TCK reset prefix and returns correct data.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// JTAG master: turns reset / IR / DR / idle commands into TCK/TMS/TDI bit plans
// for a 1149.1 TAP and gathers TDO into a response word.
module jtag_scan_sequencer #(
    parameter int IR_WIDTH = 5,
    parameter int DR_WIDTH = 32,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                trst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_type,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                tap_synced,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    localparam int CW  = ($clog2(DR_WIDTH + 12) > 17) ? $clog2(DR_WIDTH + 12) : 17;
    localparam int KW  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  IRW      = CW'(IR_WIDTH);
    localparam logic [CW-1:0]  DRW      = CW'(DR_WIDTH);
    localparam logic [CW-1:0]  PRE      = CW'(6);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

    typedef enum logic [1:0] {C_RESET = 2'b00, C_IR = 2'b01, C_DR = 2'b10, C_IDLE = 2'b11} cmd_e;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TCK_LO, S_TCK_HI, S_RSP} state_e;

    state_e              state_q;
    cmd_e                type_q;
    logic                pre_q;
    logic [DR_WIDTH-1:0] data_q;
    logic [DR_WIDTH-1:0] rsp_q;
    logic [CW-1:0]       bit_q;
    logic [CW-1:0]       total_q;
    logic [DVW-1:0]      div_q;
    logic                shift_q;
    logic [KW-1:0]       k_q;
    logic                cmd_ready_q, rsp_valid_q, busy_q, synced_q;
    logic                tck_q, tms_q, tdi_q;

    logic [CW-1:0] pidx, j, body, total_c;
    logic          p_tms, p_tdi, p_shift;
    logic [KW-1:0] p_k;

    // Plan lookup for the bit about to be driven: bit 0 from LOAD, else the next bit.
    always_comb begin
        pidx    = (state_q == S_LOAD) ? '0 : bit_q + CW'(1);
        j       = (pre_q && pidx >= PRE) ? pidx - PRE : pidx;
        p_tms   = 1'b0;
        p_shift = 1'b0;
        p_k     = '0;
        if (pre_q && pidx < PRE) begin
            p_tms = (pidx != CW'(5));
        end else begin
            case (type_q)
                C_IR: begin
                    if (j < CW'(4)) begin
                        p_tms = (j < CW'(2));
                    end else if (j < IRW + CW'(4)) begin
                        p_shift = 1'b1;
                        p_k     = KW'(j - CW'(4));
                        p_tms   = (j == IRW + CW'(3));
                    end else begin
                        p_tms = (j == IRW + CW'(4));
                    end
                end
                C_DR: begin
                    if (j < CW'(3)) begin
                        p_tms = (j == '0);
                    end else if (j < DRW + CW'(3)) begin
                        p_shift = 1'b1;
                        p_k     = KW'(j - CW'(3));
                        p_tms   = (j == DRW + CW'(2));
                    end else begin
                        p_tms = (j == DRW + CW'(3));
                    end
                end
                default: ;
            endcase
        end
        p_tdi = p_shift & data_q[p_k];

        case (type_q)
            C_IR:    body = IRW + CW'(6);
            C_DR:    body = DRW + CW'(5);
            C_IDLE:  body = CW'(data_q[15:0]);
            default: body = '0;
        endcase
        total_c = body + (pre_q ? PRE : '0);
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            state_q     <= S_IDLE;
            type_q      <= C_RESET;
            pre_q       <= 1'b0;
            data_q      <= '0;
            rsp_q       <= '0;
            bit_q       <= '0;
            total_q     <= '0;
            div_q       <= '0;
            shift_q     <= 1'b0;
            k_q         <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            synced_q    <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        type_q      <= cmd_e'(cmd_type);
                        // An unsynced TAP gets the reset plan in front of any command.
                        pre_q       <= !synced_q || (cmd_type == C_RESET);
                        data_q      <= (cmd_type == C_IR) ? DR_WIDTH'(cmd_ir) : cmd_dr;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rsp_q   <= '0;
                    bit_q   <= '0;
                    total_q <= total_c;
                    if (total_c == '0) begin
                        state_q     <= S_RSP;
                        rsp_valid_q <= 1'b1;
                        synced_q    <= 1'b1;
                    end else begin
                        state_q <= S_TCK_LO;
                        tck_q   <= 1'b0;
                        tms_q   <= p_tms;
                        tdi_q   <= p_tdi;
                        shift_q <= p_shift;
                        k_q     <= p_k;
                        div_q   <= DIV_LAST;
                    end
                end
                S_TCK_LO: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DVW'(1);
                    end else begin
                        state_q <= S_TCK_HI;
                        tck_q   <= 1'b1;
                        div_q   <= DIV_LAST;
                        if (shift_q) rsp_q[k_q] <= tdo;
                    end
                end
                S_TCK_HI: begin
                    if (div_q != '0) begin
                        div_q <= div_q - DVW'(1);
                    end else if (bit_q == total_q - CW'(1)) begin
                        state_q     <= S_RSP;
                        tck_q       <= 1'b0;
                        tms_q       <= 1'b0;
                        tdi_q       <= 1'b0;
                        shift_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        synced_q    <= 1'b1;
                    end else begin
                        state_q <= S_TCK_LO;
                        bit_q   <= bit_q + CW'(1);
                        tck_q   <= 1'b0;
                        tms_q   <= p_tms;
                        tdi_q   <= p_tdi;
                        shift_q <= p_shift;
                        k_q     <= p_k;
                        div_q   <= DIV_LAST;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_q;
    assign busy       = busy_q;
    assign tap_synced = synced_q;
    assign tck        = tck_q;
    assign tms        = tms_q;
    assign tdi        = tdi_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: a behavioural 1149.1 TAP on the pins plus a
// command-level expectation model (TCK counts, captured data, TAP registers).
module tb_jtag_scan_sequencer;
    localparam int IRW = 5;
    localparam int DRW = 32;
    localparam int DIV = 4;
    localparam logic [IRW-1:0] IR_CAPT = 5'b01111;

    logic           clk = 1'b0;
    logic           trst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_type = 2'b00;
    logic [IRW-1:0] cmd_ir = '0;
    logic [DRW-1:0] cmd_dr = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [DRW-1:0] rsp_data;
    logic           busy, tap_synced, tck, tms, tdi;
    logic           tdo = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit m_synced = 1'b0;

    jtag_scan_sequencer #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .CLK_DIV(DIV)) dut (
        .clk(clk), .trst_n(trst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .tap_synced(tap_synced),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural TAP
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR} tap_e;
    tap_e           tst = TLR;
    logic [DRW-1:0] dr_in = '0, dr_sr = '0, dr_out = '0;
    logic [IRW-1:0] ir_sr = '0, instr = '0;
    int             tck_cnt = 0, shift_cnt = 0;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PSDR;
            PSDR:  return m ? EX2DR : PSDR;
            EX2DR: return m ? UPDR  : SHDR;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PSIR;
            PSIR:  return m ? EX2IR : PSIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tst   = TLR;
            instr = '0;
        end else begin
            tck_cnt++;
            case (tst)
                CAPDR: dr_sr = dr_in;
                SHDR:  begin dr_sr = {tdi, dr_sr[DRW-1:1]}; shift_cnt++; end
                UPDR:  dr_out = dr_sr;
                CAPIR: ir_sr = IR_CAPT;
                SHIR:  ir_sr = {tdi, ir_sr[IRW-1:1]};
                UPIR:  instr = ir_sr;
                default: ;
            endcase
            tst = tap_next(tst, tms);
        end
    end

    always @(negedge tck or negedge trst_n) begin
        if (!trst_n) tdo = 1'b0;
        else tdo = (tst == SHDR) ? dr_sr[0] : (tst == SHIR) ? ir_sr[0] : 1'b0;
    end

    // Pin-timing monitor: phase lengths and tms/tdi only moving while tck is low.
    int   hi_len = 0, lo_len = 0, hi_bad = 0, lo_bad = 0, edge_bad = 0, rises = 0;
    bit   lo_valid = 1'b0;
    logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;
    always @(negedge clk) begin
        if (!trst_n) begin
            lo_valid = 1'b0;
            hi_len   = 0;
        end else begin
            if (tck && !prev_tck) begin
                if (lo_valid && lo_len != DIV) lo_bad++;
                hi_len = 1;
                rises++;
            end else if (!tck && prev_tck) begin
                if (hi_len != DIV) hi_bad++;
                lo_valid = 1'b1;
                lo_len   = 1;
            end else if (tck) begin
                hi_len++;
            end else begin
                lo_len++;
            end
            if ((tms !== prev_tms || tdi !== prev_tdi) && tck) edge_bad++;
            if (cmd_valid && cmd_ready) lo_valid = 1'b0;
        end
        prev_tck = tck;
        prev_tms = tms;
        prev_tdi = tdi;
    end

    task automatic run_cmd(input logic [1:0] t, input logic [IRW-1:0] ir,
                           input logic [DRW-1:0] dr, input logic [DRW-1:0] din, input int hold);
        int             st_tck, cyc, exp_cnt, pre;
        logic [DRW-1:0] exp_rsp, held;
        bit             ok, synced_at_start;
        synced_at_start = m_synced;
        pre = (!m_synced || t == 2'b00) ? 6 : 0;
        case (t)
            2'b00:   begin exp_cnt = 6;             exp_rsp = '0; end
            2'b01:   begin exp_cnt = pre + IRW + 6; exp_rsp = DRW'(IR_CAPT); end
            2'b10:   begin exp_cnt = pre + DRW + 5; exp_rsp = din; end
            default: begin exp_cnt = pre + int'(dr[15:0]); exp_rsp = '0; end
        endcase
        dr_in = din;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = t; cmd_ir = ir; cmd_dr = dr;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
        chk("cmd_ready_before_accept", cmd_ready, 1);
        st_tck = tck_cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_type = 2'($urandom); cmd_ir = IRW'($urandom); cmd_dr = $urandom;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!rsp_valid && cyc < 2000);
        chk("rsp_valid_arrives", rsp_valid, 1);
        if (t == 2'b11 && dr[15:0] == 16'd0 && synced_at_start) chk("idle0_latency_le2", cyc <= 2, 1);
        held = rsp_data;
        ok = 1'b1;
        if (hold > 0) begin cmd_valid = 1'b1; cmd_type = 2'b10; end
        repeat (hold) begin
            @(negedge clk);
            if (rsp_data !== held || !rsp_valid || cmd_ready || tck || !busy) ok = 1'b0;
        end
        cmd_valid = 1'b0;
        if (hold > 0) chk("rsp_hold_stable", ok, 1);
        chk("tck_count", tck_cnt - st_tck, exp_cnt);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("tap_synced", tap_synced, 1);
        chk("tap_in_rti", tst == RTI, 1);
        if (t == 2'b01) chk("tap_instr", instr, ir);
        if (t == 2'b10) chk("tap_dr_out", dr_out, dr);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_cmd_ready", cmd_ready, 1);
        chk("post_hs_busy", busy, 0);
        m_synced = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        trst_n = 1'b0;
        repeat (3) @(negedge clk);
        trst_n = 1'b1;
        m_synced = 1'b0;
    endtask

    initial begin
        int cyc, st_shift, t, hold;
        bit ok;
        logic [DRW-1:0] d;

        #23;
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tap_synced", tap_synced, 0);
        @(negedge clk);
        trst_n = 1'b1;

        run_cmd(2'b10, '0, 32'hA5A50F0F, 32'h12345678, 0);
        run_cmd(2'b01, 5'b00011, '0, '0, 0);
        run_cmd(2'b11, '0, 32'd0, '0, 0);
        run_cmd(2'b11, '0, 32'd3, '0, 0);
        run_cmd(2'b10, IRW'($urandom), $urandom, $urandom, 20);

        // Abort a DR scan after 10 shift bits.
        d = $urandom;
        dr_in = $urandom;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_dr = d;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
        st_shift = shift_cnt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0;
        while (shift_cnt - st_shift < 10 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("abort_reached_shift10", shift_cnt - st_shift, 10);
        trst_n = 1'b0;
        #1;
        chk("abort_tck", tck, 0);
        chk("abort_tms", tms, 1);
        chk("abort_tdi", tdi, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tap_synced", tap_synced, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        ok = !rsp_valid;
        repeat (4) begin @(negedge clk); if (rsp_valid) ok = 1'b0; end
        trst_n = 1'b1;
        m_synced = 1'b0;
        repeat (30) begin @(negedge clk); if (rsp_valid || busy) ok = 1'b0; end
        chk("abort_no_response", ok, 1);
        run_cmd(2'b10, '0, $urandom, $urandom, 0);

        pulse_reset();
        run_cmd(2'b11, '0, 32'd2, '0, 0);
        run_cmd(2'b00, '0, '0, '0, 1);

        for (int i = 0; i < 24; i++) begin
            t = int'($urandom_range(0, 3));
            d = (t == 3) ? DRW'($urandom_range(0, 6)) : $urandom;
            hold = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pulse_reset();
            run_cmd(2'(t), IRW'($urandom), d, $urandom, hold);
        end

        chk("mon_tck_pulses_seen", rises > 100, 1);
        chk("mon_tck_high_len_bad", hi_bad, 0);
        chk("mon_tck_low_len_bad", lo_bad, 0);
        chk("mon_tms_tdi_move_at_tck_high", edge_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
